qracc_sram_bridge: RTL and testbench

Bridges the generic 32-bit `qracc_ctrl_interface` (slave side) to the row-wide `sram_itf` (master side) of the QRAcc SRAM macro. Writes are packed word by word into a `numCols`-wide row buffer. A row write request is issued when the last word of a row arrives. Reads fetch the whole row and return the addressed 32-bit word. One transaction is in flight at a time; the block sits directly upstream of the SRAM digital controller.

---
 rtl/qracc_pkg.sv | 15 +
 rtl/qracc_itf.sv | 41 ++++
 rtl/qracc_row_buffer.sv | 47 ++++
 rtl/qracc_sram_bridge.sv | 126 ++++++++++++
 tb/tb_qracc_sram_bridge.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qracc_pkg.sv
// Shared QRAcc types and constants.
// Bridge FSM encoding and the control-bus word width.
package qracc_pkg;

    localparam int ctrlWordBits = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_WR  = 3'd1,
        REQ_RD  = 3'd2,
        WAIT_RD = 3'd3,
        RESP    = 3'd4
    } qracc_bridge_state_t;

endpackage

// File: rtl/qracc_itf.sv
// Control-bus and SRAM-macro interfaces used by the QRAcc bridge.
// The SRAM signal names follow the macro's own pin naming.
interface qracc_ctrl_interface;
    logic [31:0] data;
    logic [31:0] addr;
    logic        wen;
    logic        valid;
    logic        ready;
    logic [31:0] read_data;

    modport slave (
        input  data, addr, wen, valid,
        output ready, read_data
    );
    modport master (
        output data, addr, wen, valid,
        input  ready, read_data
    );
endinterface

interface sram_itf #(
    parameter int numRows = 128,
    parameter int numCols = 32
);
    logic                       rq_wr_i;
    logic                       rq_valid_i;
    logic [numCols-1:0]         wr_data_i;
    logic [$clog2(numRows)-1:0] addr_i;
    logic                       rq_ready_o;
    logic                       rd_valid_o;
    logic [numCols-1:0]         rd_data_o;

    modport master (
        output rq_wr_i, rq_valid_i, wr_data_i, addr_i,
        input  rq_ready_o, rd_valid_o, rd_data_o
    );
    modport slave (
        input  rq_wr_i, rq_valid_i, wr_data_i, addr_i,
        output rq_ready_o, rd_valid_o, rd_data_o
    );
endinterface

// File: rtl/qracc_row_buffer.sv
// Row-wide write buffer packed one 32-bit word at a time,
// plus a word-select mux for extracting a word from a full row.
module qracc_row_buffer
    import qracc_pkg::*;
#(
    parameter int numCols     = 32,
    parameter int WordIdxBits = 1
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   we_i,
    input  logic [WordIdxBits-1:0] widx_i,
    input  logic [31:0]            wdata_i,
    output logic [numCols-1:0]     row_o,
    input  logic [numCols-1:0]     sel_row_i,
    input  logic [WordIdxBits-1:0] sel_idx_i,
    output logic [31:0]            sel_word_o
);

    localparam int WordsPerRow = numCols / ctrlWordBits;

    logic [numCols-1:0] buf_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            buf_q <= '0;
        end else if (we_i) begin
            for (int i = 0; i < WordsPerRow; i++) begin
                if (widx_i == WordIdxBits'(i)) begin
                    buf_q[i*ctrlWordBits +: ctrlWordBits] <= wdata_i;
                end
            end
        end
    end

    assign row_o = buf_q;

    always_comb begin
        sel_word_o = '0;
        for (int i = 0; i < WordsPerRow; i++) begin
            if (sel_idx_i == WordIdxBits'(i)) begin
                sel_word_o = sel_row_i[i*ctrlWordBits +: ctrlWordBits];
            end
        end
    end

endmodule

// File: rtl/qracc_sram_bridge.sv
// Bridges the 32-bit QRAcc control bus to the row-wide SRAM request port.
// One transaction in flight; writes commit a row when its last word lands.
module qracc_sram_bridge
    import qracc_pkg::*;
#(
    parameter int numRows = 128,
    parameter int numCols = 32
) (
    input  logic               clk,
    input  logic               nrst,
    qracc_ctrl_interface.slave ctrl,
    sram_itf.master            sram,
    output logic               busy_o,
    output logic [15:0]        rows_written_o
);

    localparam int WordsPerRow = numCols / ctrlWordBits;
    localparam int WordIdxBits = (WordsPerRow > 1) ? $clog2(WordsPerRow) : 1;
    localparam int RowBits     = $clog2(numRows);
    // A single-word row has no word field, so the row starts at bit 2.
    localparam int RowLsb      = (WordsPerRow > 1) ? 2 + WordIdxBits : 2;

    if (numCols % ctrlWordBits != 0) begin : g_cols_chk
        $error("numCols must be a multiple of 32");
    end

    qracc_bridge_state_t    state_q, state_d;
    logic [RowBits-1:0]     row_q, row_d;
    logic [WordIdxBits-1:0] idx_q, idx_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [15:0]            cnt_q, cnt_d;

    logic [WordIdxBits-1:0] widx;
    logic [RowBits-1:0]     rrow;
    logic                   last;
    logic                   buf_we;
    logic [numCols-1:0]     row_buf;
    logic [31:0]            rd_word;

    assign widx   = (WordsPerRow == 1) ? '0 : ctrl.addr[2 +: WordIdxBits];
    assign rrow   = ctrl.addr[RowLsb +: RowBits];
    assign last   = (widx == WordIdxBits'(WordsPerRow - 1));
    assign buf_we = (state_q == IDLE) && ctrl.valid && ctrl.wen;

    qracc_row_buffer #(
        .numCols     (numCols),
        .WordIdxBits (WordIdxBits)
    ) u_buf (
        .clk        (clk),
        .nrst       (nrst),
        .we_i       (buf_we),
        .widx_i     (widx),
        .wdata_i    (ctrl.data),
        .row_o      (row_buf),
        .sel_row_i  (sram.rd_data_o),
        .sel_idx_i  (idx_q),
        .sel_word_o (rd_word)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (ctrl.valid) begin
                    if (ctrl.wen && !last) begin
                        state_d = RESP;
                    end else if (ctrl.wen) begin
                        row_d   = rrow;
                        state_d = REQ_WR;
                    end else begin
                        row_d   = rrow;
                        idx_d   = widx;
                        state_d = REQ_RD;
                    end
                end
            end
            REQ_WR: begin
                if (sram.rq_ready_o) begin
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    state_d = RESP;
                end
            end
            REQ_RD: begin
                if (sram.rq_ready_o) state_d = WAIT_RD;
            end
            WAIT_RD: begin
                if (sram.rd_valid_o) begin
                    rdata_d = rd_word;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            row_q   <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ctrl.ready      = (state_q == RESP);
    assign ctrl.read_data  = rdata_q;
    assign sram.rq_valid_i = (state_q == REQ_WR) || (state_q == REQ_RD);
    assign sram.rq_wr_i    = (state_q == REQ_WR);
    assign sram.wr_data_i  = (state_q == REQ_WR) ? row_buf : '0;
    assign sram.addr_i     = row_q;
    assign busy_o          = (state_q != IDLE);
    assign rows_written_o  = cnt_q;

endmodule

// File: tb/tb_qracc_sram_bridge.sv
// Testbench for qracc_sram_bridge: a 128-bit-row instance driven from
// vectors and random traffic against a reference model, plus a 32-bit-row instance.
module tb_qracc_sram_bridge;

    logic clk;
    logic nrst;
    logic        busy128, busy32;
    logic [15:0] rw128, rw32;

    int checks;
    int errors;

    qracc_ctrl_interface c128 ();
    qracc_ctrl_interface c32 ();
    sram_itf #(.numRows(128), .numCols(128)) s128 ();
    sram_itf #(.numRows(128), .numCols(32))  s32 ();

    qracc_sram_bridge #(.numRows(128), .numCols(128)) u128 (
        .clk            (clk),
        .nrst           (nrst),
        .ctrl           (c128),
        .sram           (s128),
        .busy_o         (busy128),
        .rows_written_o (rw128)
    );

    qracc_sram_bridge #(.numRows(128), .numCols(32)) u32 (
        .clk            (clk),
        .nrst           (nrst),
        .ctrl           (c32),
        .sram           (s32),
        .busy_o         (busy32),
        .rows_written_o (rw32)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // behavioural reference: SRAM contents, word buffer, commit count
    logic [127:0] smem [128];
    logic [127:0] mmem [128];
    logic [31:0]  mbuf [4];
    int           mcnt;
    logic [31:0]  mrd;

    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  data;
        logic         wen;
        int           rqd;
        int           rdd;
        bit           ereq;
        logic [6:0]   eaddr;
        logic [127:0] edata;
        logic [31:0]  erd;
        int           elat;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic w,
                              output bit ereq, output logic [6:0] eaddr,
                              output logic [127:0] edata, output logic [31:0] erd);
        int r;
        int wi;
        r  = (a / 16) % 128;
        wi = (a / 4) % 4;
        eaddr = 7'(r);
        edata = '0;
        if (w) begin
            mbuf[wi] = d;
            ereq = (wi == 3);
            if (ereq) begin
                edata = {mbuf[3], mbuf[2], mbuf[1], mbuf[0]};
                mmem[r] = edata;
                if (mcnt < 65535) mcnt++;
            end
        end else begin
            ereq = 1;
            mrd = mmem[r][wi*32 +: 32];
        end
        erd = mrd;
    endtask

    // Acts as master on c128 and as the SRAM macro on s128.
    task automatic run128(input logic [31:0] a, input logic [31:0] d, input logic w,
                          input int rqd, input int rdd, input bit stray,
                          output bit req_seen, output logic req_wr,
                          output logic [6:0] req_addr, output logic [127:0] req_data,
                          output int lat, output bit stable);
        int cyc;
        int rqw;
        int rdc;
        bit acc_pend;
        bit done;
        cyc = 0; rqw = 0; rdc = -1; acc_pend = 0; done = 0;
        req_seen = 0; req_wr = 0; req_addr = '0; req_data = '0;
        lat = -1; stable = 1;
        @(negedge clk);
        c128.addr = a; c128.data = d; c128.wen = w; c128.valid = 1;
        while (!done && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            s128.rd_valid_o = 0;
            if (acc_pend) begin
                acc_pend = 0;
                if (req_wr) smem[req_addr] = req_data;
                else rdc = 0;
            end
            if (c128.ready) begin
                done = 1;
                lat = cyc;
                c128.valid = 0;
                s128.rq_ready_o = 0;
            end else begin
                if (s128.rq_valid_i) begin
                    if (!req_seen) begin
                        req_seen = 1;
                        req_wr   = s128.rq_wr_i;
                        req_addr = s128.addr_i;
                        req_data = s128.wr_data_i;
                    end else if (s128.rq_wr_i !== req_wr || s128.addr_i !== req_addr ||
                                 s128.wr_data_i !== req_data) begin
                        stable = 0;
                    end
                    if (rqw < rqd) begin
                        rqw++;
                        s128.rq_ready_o = 0;
                    end else begin
                        s128.rq_ready_o = 1;
                        acc_pend = 1;
                    end
                end else begin
                    s128.rq_ready_o = 0;
                end
                if (rdc >= 0) begin
                    if (rdc == rdd) begin
                        s128.rd_valid_o = 1;
                        s128.rd_data_o  = smem[req_addr];
                        rdc = -1;
                    end else begin
                        rdc++;
                    end
                end else if (stray) begin
                    s128.rd_valid_o = 1;
                    s128.rd_data_o  = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
        if (!done) begin
            c128.valid = 0;
            s128.rq_ready_o = 0;
            s128.rd_valid_o = 0;
            chk("timeout", 1'b1, 1'b0);
        end
    endtask

    task automatic do128(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input int rqd, input int rdd, input bit stray, input bit chk_stable);
        bit ereq, seen, stable;
        logic [6:0] eaddr, raddr;
        logic [127:0] edata, rdata;
        logic [31:0] erd;
        logic rwr;
        int lat, elat;
        model_step(a, d, w, ereq, eaddr, edata, erd);
        run128(a, d, w, rqd, rdd, stray, seen, rwr, raddr, rdata, lat, stable);
        if (!w) elat = 3 + rqd + rdd;
        else if (ereq) elat = 2 + rqd;
        else elat = 1;
        chk("req_seen", seen, ereq);
        if (ereq) begin
            chk("req_wr", rwr, w);
            chk("req_addr", raddr, eaddr);
            if (w) chk("req_data", rdata, edata);
        end
        chk("latency", lat, elat);
        chk("read_data", c128.read_data, erd);
        chk("rows_written", rw128, mcnt);
        if (chk_stable) chk("req_stable", stable, 1'b1);
        @(posedge clk);
        #1;
        chk("ready_pulse", c128.ready, 1'b0);
    endtask

    initial begin
        bit seen, stable, ereq;
        logic rwr;
        logic [6:0] raddr, eaddr;
        logic [127:0] rdata, edata, v;
        logic [31:0] erd;
        int lat;
        bit rv_seen;

        checks = 0;
        errors = 0;
        nrst = 0;
        c128.data = '0; c128.addr = '0; c128.wen = 0; c128.valid = 0;
        c32.data = '0;  c32.addr = '0;  c32.wen = 0;  c32.valid = 0;
        s128.rq_ready_o = 0; s128.rd_valid_o = 0; s128.rd_data_o = '0;
        s32.rq_ready_o = 0;  s32.rd_valid_o = 0;  s32.rd_data_o = '0;
        for (int i = 0; i < 128; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            smem[i] = v;
            mmem[i] = v;
        end
        for (int i = 0; i < 4; i++) mbuf[i] = '0;
        mcnt = 0;
        mrd = '0;

        tbl[0] = '{32'h20, 32'h11111111, 1'b1, 0, 0, 1'b0, 7'd0, 128'h0, 32'h0, 1};
        tbl[1] = '{32'h24, 32'h22222222, 1'b1, 0, 0, 1'b0, 7'd0, 128'h0, 32'h0, 1};
        tbl[2] = '{32'h28, 32'h33333333, 1'b1, 0, 0, 1'b0, 7'd0, 128'h0, 32'h0, 1};
        tbl[3] = '{32'h2C, 32'h44444444, 1'b1, 0, 0, 1'b1, 7'd2,
                   128'h44444444_33333333_22222222_11111111, 32'h0, 2};
        tbl[4] = '{32'h24, 32'h0, 1'b0, 0, 3, 1'b1, 7'd2, 128'h0, 32'h22222222, 6};
        tbl[5] = '{32'h2C, 32'h0, 1'b0, 2, 0, 1'b1, 7'd2, 128'h0, 32'h44444444, 5};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy128, 1'b0);
        chk("rst_rq_valid", s128.rq_valid_i, 1'b0);
        chk("rst_rq_wr", s128.rq_wr_i, 1'b0);
        chk("rst_wr_data", s128.wr_data_i, 128'h0);
        chk("rst_addr", s128.addr_i, 7'h0);
        chk("rst_ready", c128.ready, 1'b0);
        chk("rst_read_data", c128.read_data, 32'h0);
        chk("rst_rows", rw128, 16'h0);
        chk("rst32_ready", {c32.ready, s32.rq_valid_i, busy32, rw32}, 19'h0);
        @(negedge clk);
        nrst = 1;
        rv_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            rv_seen = rv_seen | s128.rq_valid_i | s32.rq_valid_i | busy128 | busy32;
        end
        chk("idle_quiet", rv_seen, 1'b0);

        // single-word rows
        @(negedge clk);
        c32.addr = 32'h14; c32.data = 32'hDEADBEEF; c32.wen = 1; c32.valid = 1;
        @(posedge clk);
        #1;
        chk("w32_rq_valid", s32.rq_valid_i, 1'b1);
        chk("w32_rq_wr", s32.rq_wr_i, 1'b1);
        chk("w32_addr", s32.addr_i, 7'd5);
        chk("w32_data", s32.wr_data_i, 32'hDEADBEEF);
        chk("w32_ready_early", c32.ready, 1'b0);
        s32.rq_ready_o = 1;
        @(posedge clk);
        #1;
        s32.rq_ready_o = 0;
        chk("w32_ready", c32.ready, 1'b1);
        chk("w32_rows", rw32, 16'd1);
        c32.valid = 0;
        @(posedge clk);
        #1;
        chk("w32_ready_pulse", c32.ready, 1'b0);
        chk("w32_rq_drop", s32.rq_valid_i, 1'b0);

        // directed vectors
        for (int i = 0; i < 6; i++) begin
            model_step(tbl[i].addr, tbl[i].data, tbl[i].wen, ereq, eaddr, edata, erd);
            run128(tbl[i].addr, tbl[i].data, tbl[i].wen, tbl[i].rqd, tbl[i].rdd, 1'b0,
                   seen, rwr, raddr, rdata, lat, stable);
            chk("vec_req", seen, tbl[i].ereq);
            if (tbl[i].ereq) chk("vec_addr", raddr, tbl[i].eaddr);
            if (tbl[i].ereq && tbl[i].wen) chk("vec_data", rdata, tbl[i].edata);
            chk("vec_lat", lat, tbl[i].elat);
            chk("vec_rdata", c128.read_data, tbl[i].erd);
            @(posedge clk);
            #1;
            chk("vec_ready_pulse", c128.ready, 1'b0);
        end

        // request held off 10 cycles with stray read strobes
        do128(32'h5C, 32'hCAFEF00D, 1'b1, 10, 0, 1'b1, 1'b1);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[3:2] = 2'd3;
            do128(a, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b1);
        end

        // async reset while waiting for read data
        @(negedge clk);
        c128.addr = 32'h90; c128.wen = 0; c128.valid = 1;
        s128.rq_ready_o = 1;
        repeat (2) @(posedge clk);
        #1;
        s128.rq_ready_o = 0;
        chk("wait_busy", busy128, 1'b1);
        chk("wait_rq_valid", s128.rq_valid_i, 1'b0);
        nrst = 0;
        #1;
        chk("mid_rst_busy", busy128, 1'b0);
        chk("mid_rst_rq_valid", s128.rq_valid_i, 1'b0);
        chk("mid_rst_ready", c128.ready, 1'b0);
        chk("mid_rst_read_data", c128.read_data, 32'h0);
        chk("mid_rst_rows", rw128, 16'h0);
        c128.valid = 0;
        for (int i = 0; i < 4; i++) mbuf[i] = '0;
        mcnt = 0;
        mrd = '0;
        @(negedge clk);
        nrst = 1;

        // buffer cleared: only word 3 of the committed row is non-zero
        do128(32'h9C, 32'hA5A5_5A5A, 1'b1, 0, 0, 1'b0, 1'b0);
        do128(32'h90, 32'h0, 1'b0, 0, 2, 1'b0, 1'b0);
        do128(32'h9C, 32'h0, 1'b0, 1, 1, 1'b0, 1'b0);
        do128(32'h24, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
